// File: rtl/gm64_button_pkg.sv
// gm64_button_pkg: shared state type and default timing for the push-button controller
package gm64_button_pkg;
    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} btn_state_t;
    localparam int DEB_10MS_27MHZ = 270000;
    localparam int LONG_1S_27MHZ  = 27000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input pin
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q, sync_d;
    assign sync_d = {sync_q[0], d};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {2{RESET_VAL}};
        else       sync_q <= sync_d;
    end
    assign q = sync_q[1];
endmodule

// File: rtl/button_ctrl.sv
// button_ctrl: debounces a push-button pin and classifies presses into level and event pulses
module button_ctrl
    import gm64_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_10MS_27MHZ,
    parameter int LONG_CYCLES     = LONG_1S_27MHZ,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pin,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("button_ctrl: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end

    logic pin_s, act;
    sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_pin),
        .q     (pin_s)
    );
    // XOR with the idle level turns the pin into 1 = pressed for either polarity
    assign act = pin_s ^ ACTIVE_LOW;

    btn_state_t    state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_flag_q, long_flag_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          deb_done;

    assign deb_done = deb_cnt_q == DEB_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = act ? DEB_PRESS : IDLE;
            DEB_PRESS:   state_d = !act ? IDLE : deb_done ? HELD : DEB_PRESS;
            HELD:        state_d = act ? HELD : DEB_RELEASE;
            DEB_RELEASE: state_d = act ? HELD : deb_done ? IDLE : DEB_RELEASE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        deb_cnt_d = '0;
        if (state_d == DEB_PRESS || state_d == DEB_RELEASE)
            deb_cnt_d = (state_d == state_q) ? deb_cnt_q + 1'b1 : DW'(1);
        // hold time only advances on pressed cycles, so release glitches freeze it
        hold_cnt_d = hold_cnt_q;
        if (state_q == DEB_PRESS)
            hold_cnt_d = '0;
        else if ((state_q == HELD || state_q == DEB_RELEASE) && act && hold_cnt_q != LONG_LAST)
            hold_cnt_d = hold_cnt_q + 1'b1;
        long_d      = state_q == HELD && hold_cnt_q == LONG_LAST && !long_flag_q;
        long_flag_d = state_q == DEB_PRESS ? 1'b0 : long_flag_q | long_d;
        press_d     = state_q == DEB_PRESS && state_d == HELD;
        release_d   = state_q == DEB_RELEASE && state_d == IDLE;
        short_d     = release_d && !long_flag_q;
        pressed_d   = state_d == HELD || state_d == DEB_RELEASE;
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: randomized and directed checks of button_ctrl against a run-length reference model
module tb_button_ctrl;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_pin = 1'b1;
    logic pressed, press_pulse, release_pulse, short_pulse, long_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no = 0;

    // model: level, run of disagreeing samples, pressed-sample count, long fired
    bit m_pressed, m_fired, m_s1, m_s2;
    int m_run, m_held;
    logic [4:0] m_out;

    button_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_pin       (btn_pin),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {pressed, press_pulse, release_pulse, short_pulse, long_pulse};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        m_pressed = 0;
        m_fired = 0;
        m_run = 0;
        m_held = 0;
        m_s1 = 1;
        m_s2 = 1;
        m_out = '0;
    endtask

    task automatic model_edge();
        bit act;
        act = !m_s2;
        m_out = '0;
        if (m_pressed && !m_fired && m_held == LONG - 1) begin
            m_out[0] = 1'b1;
            m_fired = 1;
        end
        if (m_pressed && act && m_held < LONG - 1) m_held++;
        m_run = (act != m_pressed) ? m_run + 1 : 0;
        if (m_run == DEB) begin
            m_pressed = !m_pressed;
            m_run = 0;
            if (m_pressed) begin
                m_out[3] = 1'b1;
                m_held = 0;
                m_fired = 0;
            end else begin
                m_out[2] = 1'b1;
                m_out[1] = !m_fired;
            end
        end
        m_out[4] = m_pressed;
        m_s2 = m_s1;
        m_s1 = btn_pin;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        if (reset) model_reset();
        else model_edge();
        #1;
        check("outs", {27'd0, outs()}, {27'd0, m_out});
    endtask

    // sel: 0 press, 1 release, 2 long; returns first edge seen or -1
    task automatic wait_pulse(input int sel, input int max, output int at);
        at = -1;
        for (int i = 0; i < max && at < 0; i++) begin
            tick();
            if ((sel == 0 && press_pulse) || (sel == 1 && release_pulse) || (sel == 2 && long_pulse))
                at = edge_no;
        end
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check("async_clear", {27'd0, outs()}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int t, a, n_long, len;
        model_reset();
        #3 check("reset_outs", {27'd0, outs()}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        edge_no = 0;

        repeat (10) tick();
        btn_pin = 1'b0;
        wait_pulse(0, 12, t);
        check("press_edge", t, 16);

        repeat (4) tick();
        btn_pin = 1'b1;
        a = edge_no;
        wait_pulse(1, 12, t);
        check("release_latency", t - a, DEB + 2);
        check("short_with_release", short_pulse, 1);
        repeat (5) tick();

        btn_pin = 1'b0; tick(); tick();
        btn_pin = 1'b1; tick();
        btn_pin = 1'b0; tick();
        btn_pin = 1'b1;
        repeat (10) tick();
        check("bounce_pressed", pressed, 0);

        btn_pin = 1'b0;
        wait_pulse(0, 12, a);
        n_long = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (long_pulse) begin
                n_long++;
                check("long_edge", edge_no - a, LONG);
            end
        end
        check("long_count", n_long, 1);
        btn_pin = 1'b1;
        wait_pulse(1, 12, t);
        check("long_no_short", short_pulse, 0);
        repeat (5) tick();

        btn_pin = 1'b0;
        wait_pulse(0, 12, a);
        repeat (8) tick();
        btn_pin = 1'b1; tick(); tick();
        btn_pin = 1'b0;
        wait_pulse(2, 30, t);
        check("glitch_long_delay", t - a, LONG + 2);
        check("glitch_still_pressed", pressed, 1);

        async_reset();
        a = edge_no;
        wait_pulse(0, 12, t);
        check("repress_after_reset", t - a, DEB + 2);
        btn_pin = 1'b1;
        repeat (10) tick();

        for (int i = 0; i < 150; i++) begin
            btn_pin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) async_reset();
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 6);
            repeat (len) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
